// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the merged playfield bottom to top, removes every
// full row by dropping the rows above it, then reports the compacted field, the
// number of rows removed and a saturating running total of removed rows.
module line_clear_ctrl #(
    parameter int ROWS    = 20,
    parameter int COLS    = 20,
    parameter int TOTAL_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] field_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] field_out,
    output logic [4:0]           lines_cleared,
    output logic [TOTAL_W-1:0]   total_lines
);

    localparam int FW = ROWS * COLS;
    localparam logic [4:0]         PTR_BOTTOM = 5'(ROWS - 1);
    localparam logic [TOTAL_W-1:0] TOTAL_MAX  = {TOTAL_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state;
    logic [FW-1:0]   work;
    logic [4:0]      ptr;
    logic [4:0]      cnt;

    logic [COLS-1:0] cur_row;
    logic            row_full;
    logic [FW-1:0]   shifted;
    logic [TOTAL_W:0] total_sum;
    logic [TOTAL_W-1:0] total_next;

    // Select the row under the pointer and test it for completeness.
    always_comb begin
        // NOTE: a default before the loop keeps this purely combinational; a
        // missing default on any path would infer a latch.
        cur_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (ptr == 5'(r)) begin
                cur_row = work[r*COLS +: COLS];
            end
        end
    end

    assign row_full = &cur_row;

    // Drop every row at or above the pointer by one and insert an empty top row.
    always_comb begin
        shifted = work;
        shifted[0 +: COLS] = '0;
        for (int r = 1; r < ROWS; r++) begin
            if (5'(r) <= ptr) begin
                shifted[r*COLS +: COLS] = work[(r-1)*COLS +: COLS];
            end
        end
    end

    // Running total clamps at the all-ones value instead of wrapping.
    assign total_sum  = {1'b0, total_lines} + (TOTAL_W + 1)'(cnt);
    assign total_next = total_sum[TOTAL_W] ? TOTAL_MAX : total_sum[TOTAL_W-1:0];

    // Status is decoded straight from the state register.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Sequencer: capture, scan, shift on full rows, publish result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            work          <= '0;
            ptr           <= '0;
            cnt           <= '0;
            field_out     <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            // NOTE: all state updates are non-blocking so every assignment in
            // this block sees the values from before the edge.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        work  <= field_in;
                        ptr   <= PTR_BOTTOM;
                        cnt   <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (row_full) begin
                        state <= S_SHIFT;
                    end else if (ptr == 5'd0) begin
                        state <= S_DONE;
                    end else begin
                        ptr <= ptr - 5'd1;
                    end
                end
                S_SHIFT: begin
                    // Pointer stays put so the row that dropped in is rechecked.
                    work  <= shifted;
                    cnt   <= cnt + 5'd1;
                    state <= S_SCAN;
                end
                S_DONE: begin
                    field_out     <= work;
                    lines_cleared <= cnt;
                    total_lines   <= total_next;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl. A default instance and a TOTAL_W=6
// instance share all stimulus; the second one exercises total saturation.
module tb_line_clear_ctrl;

    localparam int ROWS = 20;
    localparam int COLS = 20;
    localparam int FW   = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [FW-1:0] field_in;

    logic          busy, done;
    logic [FW-1:0] field_out;
    logic [4:0]    lines_cleared;
    logic [15:0]   total_lines;

    logic          busy6, done6;
    logic [FW-1:0] field_out6;
    logic [4:0]    lines_cleared6;
    logic [5:0]    total_lines6;

    int checks = 0;
    int errors = 0;

    int exp_total  = 0;
    int exp_total6 = 0;

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .TOTAL_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .field_in      (field_in),
        .busy          (busy),
        .done          (done),
        .field_out     (field_out),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .TOTAL_W(6)) dut6 (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .field_in      (field_in),
        .busy          (busy6),
        .done          (done6),
        .field_out     (field_out6),
        .lines_cleared (lines_cleared6),
        .total_lines   (total_lines6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation: start at edge k, wait for done, compare latency and result.
    task automatic run_op(input string tag, input logic [FW-1:0] f, input int exp_lat,
                          input logic [FW-1:0] exp_field, input int exp_lines, input bit poke);
        int  lat;
        bit  seen;
        @(posedge clk); #1;
        start    = 1'b1;
        field_in = f;
        @(posedge clk); #1;          // edge k has captured field_in
        start    = 1'b0;
        field_in = ~f;               // later input changes must not matter
        check({tag, "_busy"}, FW'(busy), FW'(1));
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start    = poke && (lat == 3);
                field_in = {FW{1'b1}};
                @(posedge clk); #1;
                lat++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, FW'(seen), FW'(1));
        check({tag, "_latency"}, FW'(lat), FW'(exp_lat));
        check({tag, "_done6"}, FW'(done6), FW'(1));
        check({tag, "_busy_in_done"}, FW'(busy), FW'(1));
        exp_total  = exp_total + exp_lines;
        exp_total6 = (exp_total6 + exp_lines > 63) ? 63 : exp_total6 + exp_lines;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, FW'(done), FW'(0));
        check({tag, "_idle"}, FW'(busy), FW'(0));
        check({tag, "_field"}, field_out, exp_field);
        check({tag, "_lines"}, FW'(lines_cleared), FW'(exp_lines));
        check({tag, "_total"}, FW'(total_lines), FW'(exp_total));
        check({tag, "_total6"}, FW'(total_lines6), FW'(exp_total6));
    endtask

    logic [FW-1:0] f_one, r_one, f_two, r_two;
    bit            done_after_reset;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        field_in = '0;

        // Bottom row full, row 18 = 0x00001 -> row 19 = 0x00001 afterwards.
        f_one = '0;
        f_one[19*COLS +: COLS] = 20'hFFFFF;
        f_one[18*COLS +: COLS] = 20'h00001;
        r_one = '0;
        r_one[19*COLS +: COLS] = 20'h00001;

        // Rows 19 and 18 full, row 17 = 0x80000 -> row 19 = 0x80000 afterwards.
        f_two = '0;
        f_two[19*COLS +: COLS] = 20'hFFFFF;
        f_two[18*COLS +: COLS] = 20'hFFFFF;
        f_two[17*COLS +: COLS] = 20'h80000;
        r_two = '0;
        r_two[19*COLS +: COLS] = 20'h80000;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", FW'(busy), FW'(0));
        check("rst_done", FW'(done), FW'(0));
        check("rst_field", field_out, '0);
        check("rst_lines", FW'(lines_cleared), FW'(0));
        check("rst_total", FW'(total_lines), FW'(0));
        reset_n = 1'b1;

        run_op("empty", '0, 21, '0, 0, 1'b0);
        run_op("one_row", f_one, 23, r_one, 1, 1'b0);
        run_op("two_rows_poke", f_two, 25, r_two, 2, 1'b1);
        // Totals 23, 43, 63, then 83 vs. saturated 63 on the narrow instance.
        run_op("all_ones_a", {FW{1'b1}}, 61, '0, 20, 1'b0);
        run_op("all_ones_b", {FW{1'b1}}, 61, '0, 20, 1'b0);
        run_op("all_ones_c", {FW{1'b1}}, 61, '0, 20, 1'b1);
        run_op("all_ones_sat", {FW{1'b1}}, 61, '0, 20, 1'b0);
        run_op("one_row_again", f_one, 23, r_one, 1, 1'b0);

        // Abort during SHIFT: SCAN at k+1 finds row 19 full, SHIFT at k+2.
        @(posedge clk); #1;
        start    = 1'b1;
        field_in = f_one;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;          // cycle k+2: SHIFT
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", FW'(busy), FW'(0));
        check("abort_done", FW'(done), FW'(0));
        check("abort_field", field_out, '0);
        check("abort_lines", FW'(lines_cleared), FW'(0));
        check("abort_total", FW'(total_lines), FW'(0));
        check("abort_total6", FW'(total_lines6), FW'(0));
        reset_n = 1'b1;
        exp_total  = 0;
        exp_total6 = 0;
        done_after_reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_after_reset = 1'b1;
        end
        check("abort_quiet", FW'(done_after_reset), FW'(0));

        run_op("restart", f_one, 23, r_one, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_clear_ctrl.md
# line_clear_ctrl

Sequencer for the playfield datapath. After the active piece is merged into the background, it takes the 400-bit field and scans it bottom to top, one row per clock. Each completely filled row is removed and every row above it drops one row. The block then returns the compacted field with the number of lines cleared, and keeps a running line total for scoring and level logic.

## Interface
Parameters:
- ROWS, 20, number of field rows
- COLS, 20, number of field columns; field width is ROWS*COLS (400 by default)
- TOTAL_W, 16, width of the running line total

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- field_in  in  ROWS*COLS  merged field; captured on the start edge
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the result is valid
- field_out  out  ROWS*COLS  compacted field; holds until the next done or reset
- lines_cleared  out  5  full rows removed in the last operation; holds
- total_lines  out  TOTAL_W  saturating running total of cleared rows

## Operation
- Row mapping:
  - Row r occupies bits [r*COLS +: COLS].
  - Row 0 is the top row; row ROWS-1 is the bottom row.
  - A row is full when all COLS bits are 1.
- Internal state:
  - work register, ROWS*COLS bits
  - row pointer ptr, 5 bits
  - clear counter cnt, 5 bits
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - If start=1: work <= field_in, ptr <= ROWS-1, cnt <= 0, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN (examines work row ptr):
  - Row full: go to SHIFT; ptr unchanged.
  - Row not full and ptr==0: go to DONE.
  - Row not full and ptr!=0: ptr <= ptr-1, stay in SCAN.
- SHIFT:
  - For every r in 1..ptr, row r <= row r-1.
  - Row 0 <= 0.
  - Rows below ptr are unchanged.
  - cnt <= cnt+1.
  - Return to SCAN with ptr unchanged, so the new contents of that row are re-checked (handles adjacent full rows).
- DONE:
  - field_out <= work, lines_cleared <= cnt.
  - total_lines <= min(total_lines+cnt, 2^TOTAL_W-1).
  - done=1 for this cycle only; go to IDLE.
- start is ignored while busy=1; there is no queuing.
- The operation always terminates. Each SHIFT inserts an empty row 0, so at most ROWS shifts can occur. An all-ones field gives cnt=ROWS and an all-zero field_out.
- COLS=0 and ROWS=0 are unsupported. ROWS must be ≤ 31.

## Timing
- Reset (reset_n=0 at an edge) returns the block to IDLE. Values after reset:
  - busy=0, done=0
  - field_out=0
  - lines_cleared=0
  - total_lines=0
  - work, ptr and cnt are cleared
- Reset mid-operation aborts the operation. No done is produced and field_out does not update.
- Cycle numbering: start is sampled at edge k.
  - busy is high from cycle k+1 through the DONE cycle.
  - SCAN cycles = ROWS+F; SHIFT cycles = F, where F is the number of rows cleared.
  - done is high in cycle k+1+ROWS+2F.
  - field_out, lines_cleared and total_lines show their new values in the cycle after done. They are registered at the DONE edge, so they are visible the cycle after the done pulse.
- The earliest accepted re-start is the cycle after DONE, when the block is back in IDLE.
- busy is a decoded state output with no extra latency. done is decoded from the DONE state.
- The result does not depend on field_in changes after edge k.

## Test plan
- Empty field, start at edge k:
  - done at cycle k+21
  - field_out=0, lines_cleared=0, total_lines=0
- Bottom row (19) full, plus row 18 = 0x00001:
  - done at k+23, lines_cleared=1
  - Row 19 = 0x00001, all other rows 0.
- Rows 19 and 18 full, row 17 = 0x80000:
  - Adjacent clears via re-check; done at k+25, lines_cleared=2.
  - Row 19 = 0x80000, all other rows 0.
  - total_lines accumulates to 3 including the previous test.
- All 400 bits set:
  - done at k+61, lines_cleared=20, field_out=0.
- Saturation:
  - Preload total_lines near max via repeated all-ones runs (TOTAL_W=6 build): total sticks at 63.
  - start pulsed while busy has no effect.
- Reset mid-operation:
  - reset_n=0 during SHIFT: next cycle busy=0, no done pulse, all outputs 0.
  - A fresh start then completes normally.
